// File: rtl/matrix_read_streamer_pkg.sv
// matrix_read_streamer_pkg
// Shared types and constants for the matrix storage readers and writers.
//   - Matrix geometry (MAX_ROWS x MAX_COLS of ELEM_W-bit elements) and slot ID width.
//   - matrix_t: one stored matrix with its row/column counts.
//   - stream_state_t: states of the read streamer FSM.
//   - mat_beat_t: one element beat with position and end-of-row / end-of-matrix marks.
//   - dims_ok(): dimension range check applied when a slot is fetched.
package matrix_read_streamer_pkg;

  localparam int MAX_ROWS = 5;
  localparam int MAX_COLS = 5;
  localparam int ELEM_W   = 8;
  localparam int MAT_ID_W = 6;

  // Index widths leave room for one value above the maximum, so a count of
  // MAX_ROWS/MAX_COLS is representable and larger stored counts can be rejected.
  localparam int ROW_IDX_W = $clog2(MAX_ROWS + 1);
  localparam int COL_IDX_W = $clog2(MAX_COLS + 1);

  typedef logic [ELEM_W-1:0]    matrix_element_t;
  typedef logic [ROW_IDX_W-1:0] row_idx_t;
  typedef logic [COL_IDX_W-1:0] col_idx_t;
  typedef logic [MAT_ID_W-1:0]  mat_id_t;

  typedef struct packed {
    row_idx_t                                     rows;
    col_idx_t                                     cols;
    matrix_element_t [MAX_ROWS-1:0][MAX_COLS-1:0] cells;
  } matrix_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } stream_state_t;

  typedef struct packed {
    matrix_element_t data;
    row_idx_t        row;
    col_idx_t        col;
    logic            last_col;
    logic            last;
  } mat_beat_t;

  // A slot is streamable only with non-zero dimensions inside the matrix bounds.
  function automatic logic dims_ok(row_idx_t rows, col_idx_t cols);
    return (rows != '0) && (cols != '0) &&
           (int'(rows) <= MAX_ROWS) && (int'(cols) <= MAX_COLS);
  endfunction

endpackage

// File: rtl/matrix_read_streamer_if.sv
// matrix_read_streamer_if
// Element stream from the matrix read streamer to a downstream formatter.
//   master (streamer): drives out_valid, out_data, out_row, out_col,
//                      out_last_col, out_last, out_rows, out_cols; samples out_ready.
//   slave (formatter): the reverse.
// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready.
// Once out_valid is high, it and every beat field stay unchanged until that
// transfer; out_valid never depends combinationally on out_ready.
// out_rows/out_cols describe the whole matrix and are stable for the stream.
interface matrix_read_streamer_if;
  import matrix_read_streamer_pkg::*;

  logic            out_valid;
  logic            out_ready;
  matrix_element_t out_data;
  row_idx_t        out_row;
  col_idx_t        out_col;
  logic            out_last_col;
  logic            out_last;
  row_idx_t        out_rows;
  col_idx_t        out_cols;

  modport master (
    output out_valid, out_data, out_row, out_col, out_last_col, out_last,
           out_rows, out_cols,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last_col, out_last,
           out_rows, out_cols,
    output out_ready
  );

endinterface

// File: rtl/matrix_rc_counter.sv
// matrix_rc_counter
// Row-major (r, c) position walker over a rows x cols matrix.
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : return to (0, 0); wins over advance
//   advance      : step to the next element in row-major order
//   rows, cols   : matrix dimensions (must be non-zero while walking)
//   r, c         : current position
//   last_col     : c is the final column of the row
//   last         : position is the final element of the matrix
// The owner stops advancing on the last element, so r never leaves the
// matrix and callers can index storage with r/c directly.
module matrix_rc_counter
  import matrix_read_streamer_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clear,
  input  logic     advance,
  input  row_idx_t rows,
  input  col_idx_t cols,
  output row_idx_t r,
  output col_idx_t c,
  output logic     last_col,
  output logic     last
);

  assign last_col = (c == cols - col_idx_t'(1));
  assign last     = last_col && (r == rows - row_idx_t'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      c <= '0;
    end else if (clear) begin
      r <= '0;
      c <= '0;
    end else if (advance) begin
      if (last_col) begin
        c <= '0;
        r <= r + row_idx_t'(1);
      end else begin
        c <= c + col_idx_t'(1);
      end
    end
  end

endmodule

// File: rtl/matrix_read_streamer.sv
// matrix_read_streamer
// Reads one matrix from storage by slot ID, validates it, snapshots it and
// streams its elements in row-major order to a downstream formatter.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, mat_id       : one-cycle request and slot to read (taken only in IDLE)
//   abort               : drop the current operation (IDLE next cycle, no done)
//   rd_id               : storage read-port slot select
//   rd_data, rd_valid   : combinational storage read data / slot valid for rd_id
//   busy                : FETCH or STREAM in progress
//   done, err           : one-cycle completion pulse; err marks a rejected slot
//   sif (master)        : element stream, see matrix_read_streamer_if
//   state_dbg           : current FSM state
module matrix_read_streamer
  import matrix_read_streamer_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  mat_id_t                      mat_id,
  input  logic                         abort,
  output mat_id_t                      rd_id,
  input  matrix_t                      rd_data,
  input  logic                         rd_valid,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  matrix_read_streamer_if.master       sif,
  output stream_state_t                state_dbg
);

  stream_state_t state_q;
  stream_state_t state_d;

  // The snapshot holds the dimensions too, so the stream is independent of
  // any storage writes after FETCH.
  matrix_t   snap_q;
  logic      err_q;

  logic      accept;
  logic      fetch_bad;
  logic      handshake;
  row_idx_t  r;
  col_idx_t  c;
  logic      last_col;
  logic      last;
  mat_beat_t beat;

  assign fetch_bad = !rd_valid || !dims_ok(rd_data.rows, rd_data.cols);
  assign handshake = (state_q == STREAM) && sif.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          accept  = 1'b1;
        end
      end
      FETCH:   state_d = fetch_bad ? DONE : STREAM;
      STREAM:  if (handshake && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_id  <= '0;
      err_q  <= 1'b0;
      snap_q <= '0;
    end else begin
      if (accept) begin
        rd_id <= mat_id;
        err_q <= 1'b0;
      end
      if ((state_q == FETCH) && !abort) begin
        if (fetch_bad) begin
          err_q <= 1'b1;
        end else begin
          snap_q <= rd_data;
        end
      end
    end
  end

  // Position resets during FETCH; it is not advanced past the last element.
  matrix_rc_counter u_rc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_q == FETCH),
    .advance  (handshake && !last),
    .rows     (snap_q.rows),
    .cols     (snap_q.cols),
    .r        (r),
    .c        (c),
    .last_col (last_col),
    .last     (last)
  );

  // Beat fields come from state, snapshot and counter registers only, so they
  // are stable across stalls; they read zero outside STREAM.
  always_comb begin
    beat = '0;
    if (state_q == STREAM) begin
      beat.data     = snap_q.cells[r][c];
      beat.row      = r;
      beat.col      = c;
      beat.last_col = last_col;
      beat.last     = last;
    end
  end

  assign sif.out_valid    = (state_q == STREAM);
  assign sif.out_data     = beat.data;
  assign sif.out_row      = beat.row;
  assign sif.out_col      = beat.col;
  assign sif.out_last_col = beat.last_col;
  assign sif.out_last     = beat.last;
  assign sif.out_rows     = snap_q.rows;
  assign sif.out_cols     = snap_q.cols;

  assign busy      = (state_q == FETCH) || (state_q == STREAM);
  assign done      = (state_q == DONE);
  assign err       = (state_q == DONE) && err_q;
  assign state_dbg = state_q;

endmodule
